iram_prog_loader: RTL



---
 rtl/iram_prog_loader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/iram_prog_loader.sv
// Initiator for the instruction-RAM byte-programming interface: each (addr, data) word becomes
// address-byte strobes, data-byte strobes and one commit pulse. Optional: IRAM_PROG_LOADER_ADDR_SKIP_EN.
module iram_prog_loader #(
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 0,
    parameter int WORD_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_last,
    output logic [7:0]            iram_prog_byte,
    output logic [1:0]            iram_prog_byte_idx,
    output logic                  iram_prog_addr_byte,
    output logic                  iram_prog_data_byte,
    output logic                  iram_prog_wr,
    output logic                  busy,
    output logic                  load_done,
    output logic                  fetch_enable_o,
    output logic [WORD_CNT_W-1:0] words_written
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    // Lowest lane >= start whose mask bit is set; result is {found, lane}.
    function automatic logic [2:0] next_lane(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int l = 3; l >= 0; l--) begin
            res = (mask[l] && (3'(l) >= start)) ? {1'b1, 2'(l)} : res;
        end
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic [1:0]              idx_r;
    logic [1:0]              idx_s;
    logic [3:0]              gap_cnt_r;
    logic [3:0]              gap_cnt_s;
    logic [DATA_W-1:0]       addr_r;
    logic [DATA_W-1:0]       data_r;
    logic                    last_r;
    logic [WORD_CNT_W-1:0]   words_r;
    logic                    done_r;
    logic                    accept_s;
    logic [3:0]              accept_mask_s;
    logic [3:0]              lane_mask_s;
    logic [2:0]              first_s;
    logic [2:0]              next_s;

    assign accept_s = wr_valid && (state_r == S_IDLE);

`ifdef IRAM_PROG_LOADER_ADDR_SKIP_EN
    logic [DATA_W-1:0] shadow_r;
    logic [3:0]        mask_r;

    // Lanes whose incoming address byte differs from what the receiver already holds.
    always_comb begin
        accept_mask_s = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            accept_mask_s[l] = (wr_addr[8*l +: 8] != shadow_r[8*l +: 8]);
        end
    end

    assign lane_mask_s = mask_r;

    // Mirror of the receiver's address shadow, updated as each address byte goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= '0;
            mask_r   <= 4'b0000;
        end else begin
            if (accept_s) begin
                mask_r <= accept_mask_s;
            end
            if (state_r == S_ADDR) begin
                shadow_r[{idx_r, 3'b000} +: 8] <= addr_r[{idx_r, 3'b000} +: 8];
            end
        end
    end
`else
    assign accept_mask_s = 4'b1111;
    assign lane_mask_s   = 4'b1111;
`endif

    // State, lane and gap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            idx_r     <= 2'd0;
            gap_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            gap_cnt_r <= gap_cnt_s;
        end
    end

    // Next-state and lane sequencing.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        gap_cnt_s = gap_cnt_r;
        first_s   = next_lane(accept_mask_s, 3'd0);
        next_s    = next_lane(lane_mask_s, {1'b0, idx_r} + 3'd1);
        case (state_r)
            S_IDLE: begin
                if (wr_valid) begin
                    if (first_s[2]) begin
                        state_s = S_ADDR;
                        idx_s   = first_s[1:0];
                    end else begin
                        state_s = S_DATA;
                        idx_s   = 2'd0;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (next_s[2]) begin
                    idx_s = next_s[1:0];
                end else begin
                    state_s = S_DATA;
                    idx_s   = 2'd0;
                end
            end
            S_DATA: begin
                if (idx_r == 2'd3) begin
                    state_s = S_WRITE;
                    idx_s   = 2'd0;
                end else begin
                    idx_s = idx_r + 2'd1;
                end
            end
            S_WRITE: begin
                idx_s = 2'd0;
                if (GAP_CYCLES > 0) begin
                    state_s   = S_GAP;
                    gap_cnt_s = GAP_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = S_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = 2'd0;
            end
        endcase
    end

    // Word capture, committed-word counter and sticky completion flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= '0;
            data_r  <= '0;
            last_r  <= 1'b0;
            words_r <= '0;
            done_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r <= wr_addr;
                data_r <= wr_data;
                last_r <= wr_last;
            end
            if (state_r == S_WRITE) begin
                words_r <= words_r + {{(WORD_CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept_s) begin
                done_r <= 1'b0;
            end else if ((state_r == S_WRITE) && last_r) begin
                done_r <= 1'b1;
            end
        end
    end

    // Interface outputs decoded purely from registered state and lane.
    always_comb begin
        wr_ready            = 1'b0;
        iram_prog_byte      = 8'h00;
        iram_prog_byte_idx  = 2'd0;
        iram_prog_addr_byte = 1'b0;
        iram_prog_data_byte = 1'b0;
        iram_prog_wr        = 1'b0;
        case (state_r)
            S_IDLE: begin
                wr_ready = 1'b1;
            end
            S_ADDR: begin
                iram_prog_addr_byte = 1'b1;
                iram_prog_byte_idx  = idx_r;
                iram_prog_byte      = addr_r[{idx_r, 3'b000} +: 8];
            end
            S_DATA: begin
                iram_prog_data_byte = 1'b1;
                iram_prog_byte_idx  = idx_r;
                iram_prog_byte      = data_r[{idx_r, 3'b000} +: 8];
            end
            S_WRITE: begin
                iram_prog_wr = 1'b1;
            end
            default: begin
                wr_ready = 1'b0;
            end
        endcase
    end

    assign busy           = (state_r != S_IDLE);
    assign load_done      = done_r;
    assign fetch_enable_o = done_r;
    assign words_written  = words_r;

endmodule
